// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pipe_pkg
// Purpose  : Shared constants and types for the MIPS front-end pipeline
//            registers (PC, IF/ID, ID/EX control).
// Contents : NOP_INSTR, default RESET_PC / CTRL_W / CNT_W, the IF/ID payload
//            struct and the per-cycle fetch event encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

  // All-zero word decodes as sll $0,$0,0, the canonical MIPS NOP.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          DEFAULT_CTRL_W   = 10;
  localparam int          DEFAULT_CNT_W    = 16;

  // IF/ID register payload, kept as one packed word so it fits a single
  // pipe_reg instance.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_t;

  // What the front end does this cycle, in priority order.
  typedef enum logic [1:0] {
    EV_SEQ    = 2'd0,
    EV_HOLD   = 2'd1,
    EV_JUMP   = 2'd2,
    EV_BRANCH = 2'd3
  } fetch_event_e;

endpackage : mips_pipe_pkg
`default_nettype wire

// File: rtl/fetch_pipe_ctrl_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg
// Purpose  : Parameterized pipeline register with asynchronous active-high
//            reset, synchronous enable and synchronous clear (clear wins).
// Ports    : clk, rst  - clock / async reset
//            en        - load d on the rising edge
//            clr       - load all-zero on the rising edge (overrides en)
//            d, q      - data in / registered data out
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : pipe_reg
`default_nettype wire

// File: rtl/fetch_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pipe_ctrl
// Purpose  : Front-end pipeline register block of the five-stage MIPS core.
//            Holds the PC and IF/ID register, drives the ID/EX control
//            register, applies load-use stalls, j-type redirects (ID) and
//            taken-branch redirects (EX), and keeps saturating stall/flush
//            counters for performance debug.
// Ports    : clk, rst                     - clock / async active-high reset
//            PCWrite, If_Id_Write, Stall  - hazard unit controls
//            Jump, Jump_Target            - j-type redirect from ID
//            Branch_Taken, Branch_Target  - branch redirect from EX
//            Instr_In                     - imem read data for PC
//            Id_Ctrl                      - decoded control bundle in ID
//            PC                           - imem address
//            If_Id_Instr/PCPlus4/Valid    - IF/ID register
//            Id_Ex_Ctrl                   - ID/EX control register
//            Stall_Count, Flush_Count     - saturating event counters
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pipe_ctrl
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CTRL_W   = DEFAULT_CTRL_W,
  parameter int          CNT_W    = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic              If_Id_Write,
  input  logic              Stall,
  input  logic              Jump,
  input  logic [31:0]       Jump_Target,
  input  logic              Branch_Taken,
  input  logic [31:0]       Branch_Target,
  input  logic [31:0]       Instr_In,
  input  logic [CTRL_W-1:0] Id_Ctrl,
  output logic [31:0]       PC,
  output logic [31:0]       If_Id_Instr,
  output logic [31:0]       If_Id_PCPlus4,
  output logic              If_Id_Valid,
  output logic [CTRL_W-1:0] Id_Ex_Ctrl,
  output logic [CNT_W-1:0]  Stall_Count,
  output logic [CNT_W-1:0]  Flush_Count
);

  localparam int IF_ID_W = $bits(if_id_t);

  fetch_event_e      fetch_ev;
  logic [31:0]       pc_q;
  logic [31:0]       pc_d;
  logic [31:0]       pc_plus4;
  logic              pc_en;
  if_id_t            if_id_q;
  if_id_t            if_id_d;
  logic              if_id_en;
  logic              if_id_flush;
  logic [CTRL_W-1:0] id_ex_ctrl_q;
  logic              id_ex_bubble;
  logic [CNT_W-1:0]  stall_count_d;
  logic [CNT_W-1:0]  stall_count_q;
  logic [CNT_W-1:0]  flush_count_d;
  logic [CNT_W-1:0]  flush_count_q;

  assign pc_plus4 = pc_q + 32'd4;

  // A taken branch overrides the hazard unit: whatever is stalled in IF/ID
  // is on the wrong path. A hold suppresses the jump; it re-asserts from ID
  // once the stall releases.
  always_comb begin
    fetch_ev = EV_SEQ;
    if (Branch_Taken) begin
      fetch_ev = EV_BRANCH;
    end else if (!PCWrite || !If_Id_Write) begin
      fetch_ev = EV_HOLD;
    end else if (Jump) begin
      fetch_ev = EV_JUMP;
    end
  end

  // Next-PC mux and IF/ID load control.
  always_comb begin
    pc_d        = pc_plus4;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    unique case (fetch_ev)
      EV_BRANCH: begin
        pc_d        = Branch_Target;
        if_id_flush = 1'b1;
      end
      EV_HOLD: begin
        // Only the registers whose enable is deasserted hold.
        pc_en    = PCWrite;
        if_id_en = If_Id_Write;
      end
      EV_JUMP: begin
        pc_d        = Jump_Target;
        if_id_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    if_id_d = '{valid: 1'b1, pc_plus4: pc_plus4, instr: Instr_In};
    if (if_id_flush) begin
      if_id_d = '{valid: 1'b0, pc_plus4: 32'h0, instr: NOP_INSTR};
    end
  end

  // A flushed IF/ID slot must not carry write or memory enables into EX.
  assign id_ex_bubble = Stall || Branch_Taken || !if_id_q.valid;

  pipe_reg #(
    .WIDTH     (32),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .clr (1'b0),
    .d   (pc_d),
    .q   (pc_q)
  );

  pipe_reg #(
    .WIDTH     (IF_ID_W),
    .RESET_VAL ('0)
  ) u_if_id_reg (
    .clk (clk),
    .rst (rst),
    .en  (if_id_en),
    .clr (1'b0),
    .d   (if_id_d),
    .q   (if_id_q)
  );

  pipe_reg #(
    .WIDTH     (CTRL_W),
    .RESET_VAL ('0)
  ) u_id_ex_reg (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (id_ex_bubble),
    .d   (Id_Ctrl),
    .q   (id_ex_ctrl_q)
  );

  // Saturating counters: stop at all-ones rather than wrapping so a long
  // debug run never reports a misleadingly small count.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (Stall && !Branch_Taken && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (if_id_flush && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign PC            = pc_q;
  assign If_Id_Instr   = if_id_q.instr;
  assign If_Id_PCPlus4 = if_id_q.pc_plus4;
  assign If_Id_Valid   = if_id_q.valid;
  assign Id_Ex_Ctrl    = id_ex_ctrl_q;
  assign Stall_Count   = stall_count_q;
  assign Flush_Count   = flush_count_q;

endmodule : fetch_pipe_ctrl
`default_nettype wire

// File: tb/tb_fetch_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pipe_ctrl
// Purpose  : Self-checking bench for fetch_pipe_ctrl. The driver applies
//            directed and random stimulus on the falling edge, advances a
//            behavioural model of the front end and queues the expected
//            register contents; a monitor pops and compares after each
//            rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pipe_ctrl;

  localparam logic [31:0] RST_PC  = 32'h0040_0000;
  localparam int          CW      = 10;
  localparam int          NW      = 4;
  localparam int          CNT_MAX = (1 << NW) - 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [CW-1:0] idex;
    int          sc;
    int          fc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          PCWrite, If_Id_Write, Stall, Jump, Branch_Taken;
  logic [31:0]   Jump_Target, Branch_Target, Instr_In;
  logic [CW-1:0] Id_Ctrl;
  logic [31:0]   PC, If_Id_Instr, If_Id_PCPlus4;
  logic          If_Id_Valid;
  logic [CW-1:0] Id_Ex_Ctrl;
  logic [NW-1:0] Stall_Count, Flush_Count;

  int   checks = 0;
  int   errors = 0;
  exp_t m;
  exp_t exp_q[$];

  fetch_pipe_ctrl #(
    .RESET_PC (RST_PC),
    .CTRL_W   (CW),
    .CNT_W    (NW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PCWrite       (PCWrite),
    .If_Id_Write   (If_Id_Write),
    .Stall         (Stall),
    .Jump          (Jump),
    .Jump_Target   (Jump_Target),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .Instr_In      (Instr_In),
    .Id_Ctrl       (Id_Ctrl),
    .PC            (PC),
    .If_Id_Instr   (If_Id_Instr),
    .If_Id_PCPlus4 (If_Id_PCPlus4),
    .If_Id_Valid   (If_Id_Valid),
    .Id_Ex_Ctrl    (Id_Ex_Ctrl),
    .Stall_Count   (Stall_Count),
    .Flush_Count   (Flush_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("pc",       PC,                    e.pc);
    chk("ifid_ins", If_Id_Instr,           e.instr);
    chk("ifid_pc4", If_Id_PCPlus4,         e.pc4);
    chk("ifid_vld", 32'(If_Id_Valid),      32'(e.valid));
    chk("idex",     32'(Id_Ex_Ctrl),       32'(e.idex));
    chk("stallcnt", 32'(Stall_Count),      32'(e.sc));
    chk("flushcnt", 32'(Flush_Count),      32'(e.fc));
  endtask

  function automatic exp_t reset_state();
    exp_t r;
    r.pc = RST_PC; r.instr = 32'h0; r.pc4 = 32'h0; r.valid = 1'b0;
    r.idex = '0; r.sc = 0; r.fc = 0;
    return r;
  endfunction

  // Front-end behaviour for one clock edge, straight from the event priority:
  // branch > hold > jump > sequential fetch.
  task automatic model_step();
    logic [31:0] old_pc;
    logic        old_valid;
    logic        flush;
    old_pc    = m.pc;
    old_valid = m.valid;
    flush     = 1'b0;
    if (Branch_Taken) begin
      m.pc  = Branch_Target;
      flush = 1'b1;
    end else if (!PCWrite || !If_Id_Write) begin
      if (PCWrite) m.pc = old_pc + 32'd4;
      if (If_Id_Write) begin
        m.instr = Instr_In; m.pc4 = old_pc + 32'd4; m.valid = 1'b1;
      end
    end else if (Jump) begin
      m.pc  = Jump_Target;
      flush = 1'b1;
    end else begin
      m.pc    = old_pc + 32'd4;
      m.instr = Instr_In; m.pc4 = old_pc + 32'd4; m.valid = 1'b1;
    end
    if (flush) begin
      m.instr = 32'h0; m.pc4 = 32'h0; m.valid = 1'b0;
      if (m.fc < CNT_MAX) m.fc++;
    end
    m.idex = (Branch_Taken || Stall || !old_valid) ? '0 : Id_Ctrl;
    if (Stall && !Branch_Taken && m.sc < CNT_MAX) m.sc++;
  endtask

  // Called on a falling edge: apply inputs, predict, queue, move to next fall.
  task automatic cyc(input logic pcw, input logic ifw, input logic stl,
                     input logic jmp, input logic [31:0] jt,
                     input logic btk, input logic [31:0] bt);
    PCWrite = pcw; If_Id_Write = ifw; Stall = stl;
    Jump = jmp; Jump_Target = jt; Branch_Taken = btk; Branch_Target = bt;
    Instr_In = $urandom();
    Id_Ctrl  = CW'($urandom());
    if (rst) m = reset_state();
    else     model_step();
    exp_q.push_back(m);
    @(negedge clk);
  endtask

  task automatic seq_cyc();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic stall_cyc();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Assert reset between edges and check that it acts without a clock.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_all(reset_state());
    m = reset_state();
    @(negedge clk);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
  endtask

  // Monitor: one queued expectation per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_all(e);
      end
    end
  end

  initial begin
    rst = 1'b1;
    PCWrite = 1'b1; If_Id_Write = 1'b1; Stall = 1'b0; Jump = 1'b0;
    Jump_Target = '0; Branch_Taken = 1'b0; Branch_Target = '0;
    Instr_In = '0; Id_Ctrl = '0;
    m = reset_state();
    @(negedge clk);
    chk_all(reset_state());
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;

    // Sequential fetch from RESET_PC.
    repeat (3) seq_cyc();
    // Branch to 0x10, then a one-cycle load-use stall there.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0010);
    seq_cyc();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0010);
    stall_cyc();
    seq_cyc();
    seq_cyc();
    // Jump to 0x100.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    seq_cyc();
    // Branch during a stall.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0200);
    seq_cyc();
    seq_cyc();
    // Jump held by a stall, then released.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
    seq_cyc();
    // Split enables: PC advances while IF/ID holds, and vice versa.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    // PC wraps past 2^32 and unaligned targets pass through.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    seq_cyc();
    seq_cyc();
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0503, 1'b0, 32'h0);
    // Saturation of the 4-bit stall counter.
    repeat (20) stall_cyc();
    @(posedge clk);
    #2;
    chk("stall_sat", 32'(Stall_Count), 32'(CNT_MAX));
    @(negedge clk);
    seq_cyc();
    async_reset();
    repeat (2) seq_cyc();

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic pcw, ifw, stl, jmp, btk;
      int   h;
      h = $urandom_range(0, 9);
      if (h < 2) begin
        pcw = 1'b0; ifw = 1'b0; stl = 1'b1;
      end else if (h == 2) begin
        pcw = 1'($urandom()); ifw = 1'($urandom()); stl = 1'($urandom());
      end else begin
        pcw = 1'b1; ifw = 1'b1; stl = 1'b0;
      end
      jmp = ($urandom_range(0, 5) == 0);
      btk = ($urandom_range(0, 9) == 0);
      cyc(pcw, ifw, stl, jmp, $urandom(), btk, $urandom());
      if (i == 300) async_reset();
    end

    seq_cyc();
    @(posedge clk);
    #2;
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_pipe_ctrl
`default_nettype wire
